// File: rtl/fret_bus_responder_if.sv
// CPU data-bus bundle between the CPU (master) and the fret responder (slave).
// Handshake: there is no valid/ready pair; the CPU presents addr (and
// write_en/wr_data for a store) for one clock, and the responder answers on
// rd_data one clock later, with sel marking that the answer came from this
// window. Every presented address is accepted; the responder never stalls.
interface fret_bus_responder_if;
  logic [15:0] addr;
  logic        write_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        sel;

  modport master (
    output addr,
    output write_en,
    output wr_data,
    input  rd_data,
    input  sel
  );

  modport slave (
    input  addr,
    input  write_en,
    input  wr_data,
    output rd_data,
    output sel
  );
endinterface

// File: rtl/fret_bus_responder.sv
// Memory-mapped fret table with a hardware player.
// Window layout (offsets from BASE):
//   0 .. NUM_FRETS-1 : table entries {note[3:0], duration[11:0]}, read/write
//   NUM_FRETS        : STATUS {running, 10'b0, idx[4:0]}, read-only
//   NUM_FRETS+1      : CTRL, write-only (reads 0), bit0 start, bit1 stop
// The player steps through the table, holding each entry's note for
// duration ticks of TICK_DIV clocks, and ends on a zero duration or at
// the end of the table.
module fret_bus_responder #(
  parameter logic [15:0] BASE      = 16'hF000,
  parameter int          NUM_FRETS = 20,
  parameter int          TICK_DIV  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  fret_bus_responder_if.slave       bus,
  output logic [3:0]                note_out,
  output logic                      running,
  output logic                      done,
  output logic [1:0]                fsm_state
);

  localparam int            TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [15:0]   STATUS_OFF = 16'(NUM_FRETS);
  localparam logic [15:0]   CTRL_OFF   = 16'(NUM_FRETS + 1);
  localparam logic [15:0]   WIN_SIZE   = 16'(NUM_FRETS + 2);
  localparam logic [5:0]    LAST_IDX1  = 6'(NUM_FRETS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Storage and state
  // ---------------------------------------------------------------------
  logic [15:0]   table_mem [NUM_FRETS];
  state_t        state;
  state_t        state_nxt;
  logic [4:0]    idx;
  logic [11:0]   remaining;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    note_q;
  logic [15:0]   rd_q;
  logic          sel_q;

  // ---------------------------------------------------------------------
  // Address decode. Addresses below BASE wrap to a large offset, so one
  // unsigned compare covers both ends of the window.
  // ---------------------------------------------------------------------
  logic [15:0] offset;
  logic        in_window;
  logic        is_entry;
  logic        is_status;
  logic        is_ctrl;
  logic        entry_wr;
  logic        ctrl_wr;
  logic        start_cmd;
  logic        stop_cmd;

  assign offset    = bus.addr - BASE;
  assign in_window = (offset < WIN_SIZE);
  assign is_entry  = (offset < STATUS_OFF);
  assign is_status = (offset == STATUS_OFF);
  assign is_ctrl   = (offset == CTRL_OFF);
  assign entry_wr  = bus.write_en && is_entry;
  assign ctrl_wr   = bus.write_en && is_ctrl;
  // Stop wins when both bits are set, so start excludes bit1.
  assign start_cmd = ctrl_wr && bus.wr_data[0] && !bus.wr_data[1];
  assign stop_cmd  = ctrl_wr && bus.wr_data[1];

  // ---------------------------------------------------------------------
  // Player helper signals
  // ---------------------------------------------------------------------
  logic        tick;
  logic        entry_end;
  logic [5:0]  next_idx;
  logic [15:0] next_entry;
  logic        next_is_end;
  logic        first_zero;

  assign tick        = (tick_cnt == TICK_LAST);
  // remaining should never be 0 in PLAY; treating it like 1 keeps the
  // player from wrapping to 4095 ticks if it ever is.
  assign entry_end   = tick && (remaining <= 12'd1);
  assign next_idx    = {1'b0, idx} + 6'd1;
  assign next_entry  = (next_idx < LAST_IDX1) ? table_mem[next_idx[4:0]] : 16'h0000;
  assign next_is_end = (next_idx >= LAST_IDX1) || (next_entry[11:0] == 12'd0);
  assign first_zero  = (table_mem[0][11:0] == 12'd0);

  // ---------------------------------------------------------------------
  // Table storage: CPU writes only; the player never modifies entries.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FRETS; i++) begin
        table_mem[i] <= 16'h0000;
      end
    end else if (entry_wr) begin
      table_mem[offset[4:0]] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Read data mux for the registered bus response.
  // ---------------------------------------------------------------------
  logic [15:0] rd_next;

  always_comb begin
    rd_next = 16'h0000;
    if (is_entry) begin
      rd_next = table_mem[offset[4:0]];
    end else if (is_status) begin
      rd_next = {running, 10'b0, idx};
    end
  end

  // Registered bus response: write-through on stores, one-cycle read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= 16'h0000;
      sel_q <= 1'b0;
    end else if (in_window) begin
      sel_q <= 1'b1;
      rd_q  <= bus.write_en ? bus.wr_data : rd_next;
    end else begin
      sel_q <= 1'b0;
      rd_q  <= 16'h0000;
    end
  end

  assign bus.rd_data = rd_q;
  assign bus.sel     = sel_q;

  // ---------------------------------------------------------------------
  // Player FSM
  // ---------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_cmd) begin
          state_nxt = first_zero ? FINISH : PLAY;
        end
      end
      PLAY: begin
        if (stop_cmd) begin
          state_nxt = IDLE;
        end else if (start_cmd) begin
          state_nxt = first_zero ? FINISH : PLAY;
        end else if (entry_end && next_is_end) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state register only.
  always_comb begin
    note_out  = (state == PLAY) ? note_q : 4'h0;
    running   = (state == PLAY);
    done      = (state == FINISH);
    fsm_state = state;
  end

  // Player datapath: index, remaining ticks, tick divider and held note.
  // A start (from IDLE or PLAY) reloads from entry 0; a natural end leaves
  // idx on the last entry played.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= 5'd0;
      remaining <= 12'd0;
      tick_cnt  <= '0;
      note_q    <= 4'h0;
    end else if (start_cmd && (state == IDLE || state == PLAY)) begin
      idx       <= 5'd0;
      remaining <= table_mem[0][11:0];
      note_q    <= table_mem[0][15:12];
      tick_cnt  <= '0;
    end else if (state == PLAY && !stop_cmd) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        if (remaining > 12'd1) begin
          remaining <= remaining - 12'd1;
        end else if (!next_is_end) begin
          idx       <= next_idx[4:0];
          remaining <= next_entry[11:0];
          note_q    <= next_entry[15:12];
        end
      end
    end
  end

endmodule

// File: tb/tb_fret_bus_responder.sv
// Directed bench for fret_bus_responder: bus read/write, basic play,
// zero-duration start, full-table play, stop/restart and async reset.
module tb_fret_bus_responder;

  localparam logic [15:0] IDLE_ADDR = 16'h0000;
  localparam logic [15:0] STATUS_A  = 16'hF014;
  localparam logic [15:0] CTRL_A    = 16'hF015;

  // Clock / reset
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fret_bus_responder_if bus ();

  logic [3:0] note_out;
  logic       running;
  logic       done;
  logic [1:0] fsm_state;

  fret_bus_responder #(
    .BASE      (16'hF000),
    .NUM_FRETS (20),
    .TICK_DIV  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .note_out  (note_out),
    .running   (running),
    .done      (done),
    .fsm_state (fsm_state)
  );

  int total;
  int bad;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present a store for one edge; returns at the negedge right after
  // the capturing edge, with the bus back to an out-of-window address.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr     = a;
    bus.wr_data  = d;
    bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.addr     = IDLE_ADDR;
  endtask

  // Driver: present a load for one edge and sample the response after it.
  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic s);
    @(negedge clk);
    bus.addr     = a;
    bus.write_en = 1'b0;
    @(negedge clk);
    d        = bus.rd_data;
    s        = bus.sel;
    bus.addr = IDLE_ADDR;
  endtask

  function automatic logic [3:0] full_code(input int i);
    return 4'((i % 15) + 1);
  endfunction

  logic [15:0] rd;
  logic        sl;
  logic [15:0] exp_note;

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    bus.addr     = IDLE_ADDR;
    bus.write_en = 1'b0;
    bus.wr_data  = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_data", bus.rd_data, 16'h0000);
    check("rst_sel", 16'(bus.sel), 16'h0000);
    check("rst_note", 16'(note_out), 16'h0000);
    check("rst_running", 16'(running), 16'h0000);
    check("rst_done", 16'(done), 16'h0000);
    reset = 1'b1;

    // 1. Read/write
    bus_write(16'hF001, 16'h4123);
    check("wr_through_data", bus.rd_data, 16'h4123);
    check("wr_through_sel", 16'(bus.sel), 16'h0001);
    bus_read(16'hF001, rd, sl);
    check("rd_entry1_data", rd, 16'h4123);
    check("rd_entry1_sel", 16'(sl), 16'h0001);
    bus_read(16'hE000, rd, sl);
    check("rd_outside_data", rd, 16'h0000);
    check("rd_outside_sel", 16'(sl), 16'h0000);
    bus_read(16'hF016, rd, sl);
    check("rd_past_end_sel", 16'(sl), 16'h0000);
    bus_read(CTRL_A, rd, sl);
    check("rd_ctrl_data", rd, 16'h0000);
    check("rd_ctrl_sel", 16'(sl), 16'h0001);
    bus_write(STATUS_A, 16'hFFFF);
    check("wr_status_through", bus.rd_data, 16'hFFFF);
    bus_read(STATUS_A, rd, sl);
    check("rd_status_idle", rd, 16'h0000);
    bus_read(16'hF000, rd, sl);
    check("rd_entry0_reset", rd, 16'h0000);

    // 2. Basic play: note 2 for 3 ticks (12 clk), note 5 for 2 ticks (8 clk)
    bus_write(16'hF000, 16'h2003);
    bus_write(16'hF001, 16'h5002);
    bus_write(16'hF002, 16'h0000);
    bus_write(CTRL_A, 16'h0001);
    for (int k = 0; k < 22; k++) begin
      exp_note = (k < 12) ? 16'h2 : (k < 20) ? 16'h5 : 16'h0;
      check($sformatf("play_note_k%0d", k), 16'(note_out), exp_note);
      check($sformatf("play_done_k%0d", k), 16'(done), (k == 20) ? 16'h1 : 16'h0);
      check($sformatf("play_run_k%0d", k), 16'(running), (k < 20) ? 16'h1 : 16'h0);
      @(negedge clk);
    end

    // 3. Zero first duration: straight to FINISH
    bus_write(16'hF000, 16'h7000);
    bus_write(CTRL_A, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("zero_run_k%0d", k), 16'(running), 16'h0000);
      check($sformatf("zero_done_k%0d", k), 16'(done), (k == 0) ? 16'h1 : 16'h0);
      @(negedge clk);
    end

    // 4. Full table: 20 notes of one tick each
    for (int i = 0; i < 20; i++) begin
      bus_write(16'hF000 + 16'(i), {full_code(i), 12'd1});
    end
    bus_write(CTRL_A, 16'h0001);
    for (int k = 0; k < 82; k++) begin
      exp_note = (k < 80) ? 16'(full_code(k / 4)) : 16'h0;
      check($sformatf("full_note_k%0d", k), 16'(note_out), exp_note);
      check($sformatf("full_done_k%0d", k), 16'(done), (k == 80) ? 16'h1 : 16'h0);
      @(negedge clk);
    end
    bus_read(STATUS_A, rd, sl);
    check("full_status", rd, 16'h0013);

    // 5a. Stop mid-entry 1
    bus_write(16'hF000, 16'h2003);
    bus_write(16'hF001, 16'h5002);
    bus_write(16'hF002, 16'h0000);
    bus_write(CTRL_A, 16'h0001);
    repeat (13) @(negedge clk);
    check("stop_pre_note", 16'(note_out), 16'h0005);
    bus_write(CTRL_A, 16'h0002);
    check("stop_note", 16'(note_out), 16'h0000);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stop_run_k%0d", k), 16'(running), 16'h0000);
      check($sformatf("stop_done_k%0d", k), 16'(done), 16'h0000);
      @(negedge clk);
    end

    // 5b. Start and stop together from IDLE: nothing starts
    bus_write(CTRL_A, 16'h0003);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("both_run_k%0d", k), 16'(running), 16'h0000);
      check($sformatf("both_done_k%0d", k), 16'(done), 16'h0000);
      check($sformatf("both_state_k%0d", k), 16'(fsm_state), 16'h0000);
      @(negedge clk);
    end

    // 5c. Restart during PLAY
    bus_write(CTRL_A, 16'h0001);
    repeat (13) @(negedge clk);
    check("restart_pre_note", 16'(note_out), 16'h0005);
    bus_write(CTRL_A, 16'h0001);
    check("restart_note", 16'(note_out), 16'h0002);
    check("restart_run", 16'(running), 16'h0001);
    bus_read(STATUS_A, rd, sl);
    check("restart_status", rd, 16'h8000);

    // 6. Async reset mid-play, between clock edges
    bus.addr = 16'hF000;
    @(negedge clk);
    check("prerst_rd", bus.rd_data, 16'h2003);
    check("prerst_run", 16'(running), 16'h0001);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_note", 16'(note_out), 16'h0000);
    check("arst_run", 16'(running), 16'h0000);
    check("arst_done", 16'(done), 16'h0000);
    check("arst_rd", bus.rd_data, 16'h0000);
    check("arst_sel", 16'(bus.sel), 16'h0000);
    check("arst_state", 16'(fsm_state), 16'h0000);
    @(negedge clk);
    reset    = 1'b1;
    bus.addr = IDLE_ADDR;
    bus_read(16'hF000, rd, sl);
    check("arst_entry0", rd, 16'h0000);
    check("arst_entry0_sel", 16'(sl), 16'h0001);
    bus_read(16'hF001, rd, sl);
    check("arst_entry1", rd, 16'h0000);
    bus_read(STATUS_A, rd, sl);
    check("arst_status", rd, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
